i2c_multi_target: RTL and testbench
===================================

I2C_MULTI_TARGET -- requirements
Module: i2c_multi_target

Interface
Parameters:
REQ-001 The block SHALL have parameter NUM_ADDR, default 2, meaning the number of independent 7-bit target addresses (channels), range 1-8.
REQ-002 The block SHALL have parameter RX_DEPTH, default 8, meaning the receive FIFO entries, power of two from 2 to 64.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning the flip-flop synchroniser depth on scl_i/sda_i, range 2-4.
REQ-004 The block SHALL have parameter GEN_CALL_EN, default 1, meaning that address 7'h00 writes are accepted on channel 0.

Ports:
REQ-005 The block SHALL have the following ports:
- clk_i  in  1  system clock, the only clock in the block.
- rst_i  in  1  reset, synchronous and active-low.
- scl_i  in  1  bus SCL, asynchronous.
- sda_i  in  1  bus SDA, asynchronous.
- scl_o  out  1  open-drain SCL: 0 pulls low (clock stretch), 1 releases.
- sda_o  out  1  open-drain SDA: 0 pulls low, 1 releases.
- addr_i  in  7*NUM_ADDR  target addresses; channel k is bits [7k+6:7k].
- rx_data_o  out  8  head of the RX FIFO.
- rx_chan_o  out  $clog2(NUM_ADDR)+1  channel tag of the head entry.
- rx_valid_o  out  1  RX FIFO is not empty.
- rx_ready_i  in  1  pops the head when rx_valid_o is 1.
- tx_data_i  in  8  read data for the master.
- tx_valid_i  in  1  tx_data_i is offered.
- tx_ready_o  out  1  a byte is needed now (the block is stretching).
- chan_o  out  $clog2(NUM_ADDR)+1  channel of the current transaction.
- rw_o  out  1  1 = master read.
- busy_o  out  1  addressed transaction is in progress.
- start_o, restart_o, stop_o  out  1 each  one-cycle event pulses.
- overflow_o  out  1  sticky flag for an RX-full NACK.

Function
REQ-006 scl_i and sda_i SHALL pass through SYNC_STAGES flip-flops; all detection SHALL use the synchronised values and the previous-cycle copies.
REQ-007 A START SHALL be a synchronised SDA 1->0 while SCL=1 and SCL was 1 in the prior cycle; it SHALL pulse start_o in IDLE, otherwise restart_o, and enter ADDR.
REQ-008 A STOP SHALL be a synchronised SDA 0->1 while SCL=1; from any state it SHALL pulse stop_o, release sda_o/scl_o, clear busy_o and enter IDLE.
REQ-009 Data bits SHALL be sampled MSB first on the synchronised SCL rising edge.
REQ-010 sda_o SHALL change only in the cycle after a synchronised SCL falling edge.
REQ-011 FSM states SHALL be IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_LOAD, RD_BYTE, RD_ACK, IGNORE.
REQ-012 ADDR: after 8 bits, address [7:1] SHALL be compared to every channel; the lowest-index match wins.
REQ-013 On an address match the block SHALL latch chan_o and rw_o=bit0 and go to ADDR_ACK.
REQ-014 General call (7'h00, rw=0, GEN_CALL_EN=1) SHALL map to channel tag NUM_ADDR; a read to 7'h00 SHALL be treated as a mismatch.
REQ-015 On a mismatch the block SHALL go to IGNORE with SDA released until START or STOP.
REQ-016 ADDR_ACK SHALL drive sda_o=0 for the ninth SCL pulse, assert busy_o, then go to WR_BYTE (rw=0) or RD_LOAD (rw=1).
REQ-017 WR_BYTE: 8 bits SHALL be assembled; if the RX FIFO is not full, the byte and tag SHALL be pushed at the 8th rising edge and ACKed in WR_ACK.
REQ-018 If the RX FIFO is full at the 8th rising edge, the byte SHALL be dropped, NACKed (SDA released), overflow_o set, and the FSM SHALL go to IGNORE.
REQ-019 RD_LOAD: with SCL low, tx_ready_o=1; while tx_valid_i=0, scl_o SHALL be held 0.
REQ-020 When tx_valid_i=1 and tx_ready_o=1, the byte SHALL be captured, scl_o released in the next cycle, and the FSM SHALL go to RD_BYTE.
REQ-021 RD_BYTE SHALL shift 8 bits onto sda_o, then release SDA.
REQ-022 RD_ACK SHALL sample SDA on the 9th rising edge: 0 (ACK) -> RD_LOAD; 1 (NACK) -> IGNORE.
REQ-023 The RX FIFO SHALL be first-in first-out with wrapping pointers and a count of width $clog2(RX_DEPTH)+1.
REQ-024 A simultaneous push and pop when full SHALL be a legal pop followed by the push being accepted (not full at the push edge); when empty, a pop SHALL be ignored.
REQ-025 overflow_o SHALL clear only on reset.
REQ-026 START during RD_BYTE/RD_LOAD SHALL release SDA and SCL in the same cycle the START is detected.

Reset
REQ-027 With rst_i=0 at a clk_i edge, the block SHALL force: FSM=IDLE, scl_o=1, sda_o=1, FIFO empty, rx_valid_o=0, tx_ready_o=0, busy_o=0, chan_o=0, rw_o=0, rx_data_o=0, rx_chan_o=0, pulses=0, overflow_o=0, synchronisers=1.
REQ-028 Reset mid-transaction SHALL release the bus within one clock and discard partial bytes.

Verification
REQ-029 Write: addr_i={7'h2A,7'h51}, master writes 0x54 then 0xA5,0x3C, STOP -> ACKs on addr and both bytes; FIFO={A5/tag1, 3C/tag1}; start_o once, stop_o once.
REQ-030 Read with stretch: master reads 0x2A; tx_valid_i delayed 50 cycles -> SCL held low 50+ cycles; byte 0x96 driven; master NACK -> IGNORE, SDA released.
REQ-031 Overflow: RX_DEPTH=2, rx_ready_i=0, write 3 bytes to 0x51 -> bytes 1-2 ACKed, byte 3 NACKed, overflow_o=1, FIFO holds first two.
REQ-032 Mismatch/general call: write to 0x13 -> no ACK, FIFO untouched; write 0x00 then 0x06 -> ACK, entry 06 tagged NUM_ADDR.
REQ-033 Restart: write 0x2A, byte 0x11, repeated START, read 0x2A -> restart_o pulses, rw_o 0->1, FIFO={11}, read proceeds.
REQ-034 Reset mid-read (rst_i=0 during bit 4) -> scl_o=1, sda_o=1 next edge; all outputs at REQ-027 values.

Source files
------------

// File: rtl/i2c_multi_target.sv
// I2C target answering up to NUM_ADDR 7-bit addresses, with an RX FIFO for writes
// and a stretch-until-valid handshake for read data.
module i2c_multi_target #(
    parameter int unsigned NUM_ADDR    = 2,
    parameter int unsigned RX_DEPTH    = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          GEN_CALL_EN = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          scl_i,
    input  logic                          sda_i,
    output logic                          scl_o,
    output logic                          sda_o,
    input  logic [7*NUM_ADDR-1:0]         addr_i,
    output logic [7:0]                    rx_data_o,
    output logic [$clog2(NUM_ADDR):0]     rx_chan_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic [$clog2(NUM_ADDR):0]     chan_o,
    output logic                          rw_o,
    output logic                          busy_o,
    output logic                          start_o,
    output logic                          restart_o,
    output logic                          stop_o,
    output logic                          overflow_o
);
    localparam int unsigned CW = $clog2(NUM_ADDR) + 1;
    localparam int unsigned AW = $clog2(RX_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(RX_DEPTH);

    localparam logic [3:0] StIdle    = 4'd0;
    localparam logic [3:0] StAddr    = 4'd1;
    localparam logic [3:0] StAddrAck = 4'd2;
    localparam logic [3:0] StWrByte  = 4'd3;
    localparam logic [3:0] StWrAck   = 4'd4;
    localparam logic [3:0] StRdLoad  = 4'd5;
    localparam logic [3:0] StRdByte  = 4'd6;
    localparam logic [3:0] StRdAck   = 4'd7;
    localparam logic [3:0] StIgnore  = 4'd8;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic scl_s, sda_s, scl_p_q, sda_p_q;
    logic start_det, stop_det, scl_rise, scl_fall;

    logic [3:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d, shift_in;
    logic          ack_q, ack_d, sda_q, sda_d, scl_q, scl_d;
    logic [CW-1:0] chan_q, chan_d, hit_chan;
    logic          rw_q, rw_d, busy_q, busy_d, ovf_q, ovf_d, addr_hit;
    logic          start_q, start_d, restart_q, restart_d, stop_q, stop_d;

    logic [7:0]    rx_mem [RX_DEPTH];
    logic [CW-1:0] tag_mem [RX_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          fifo_full, pop, push, push_room;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_p_q    <= scl_s;
            sda_p_q    <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign start_det = scl_s & scl_p_q & sda_p_q & ~sda_s;
    assign stop_det  = scl_s & scl_p_q & ~sda_p_q & sda_s;
    assign scl_rise  = scl_s & ~scl_p_q;
    assign scl_fall  = ~scl_s & scl_p_q;
    assign shift_in  = {shift_q[6:0], sda_s};

    // Address 7'h00 is reserved for general call; it never matches a channel register.
    always_comb begin
        addr_hit = 1'b0;
        hit_chan = '0;
        if (shift_in[7:1] == 7'h00) begin
            if (GEN_CALL_EN && !shift_in[0]) begin
                addr_hit = 1'b1;
                hit_chan = CW'(NUM_ADDR);
            end
        end else begin
            for (int k = NUM_ADDR - 1; k >= 0; k--) begin
                if (addr_i[7*k +: 7] == shift_in[7:1]) begin
                    addr_hit = 1'b1;
                    hit_chan = CW'(k);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ack_d     = ack_q;
        sda_d     = sda_q;
        scl_d     = scl_q;
        chan_d    = chan_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        ovf_d     = ovf_q;
        start_d   = 1'b0;
        restart_d = 1'b0;
        stop_d    = 1'b0;
        push      = 1'b0;
        if (stop_det) begin
            stop_d  = 1'b1;
            state_d = StIdle;
            sda_d   = 1'b1;
            scl_d   = 1'b1;
            busy_d  = 1'b0;
        end else if (start_det) begin
            start_d   = (state_q == StIdle);
            restart_d = (state_q != StIdle);
            state_d   = StAddr;
            cnt_d     = '0;
            ack_d     = 1'b0;
            sda_d     = 1'b1;
            scl_d     = 1'b1;
        end else begin
            case (state_q)
                StAddr: if (scl_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        ack_d = 1'b0;
                        if (addr_hit) begin
                            chan_d  = hit_chan;
                            rw_d    = shift_in[0];
                            busy_d  = 1'b1;
                            state_d = StAddrAck;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = StIgnore;
                        end
                    end
                end
                // First falling edge starts the ACK, the second ends the ninth pulse.
                StAddrAck, StWrAck: if (scl_fall) begin
                    if (!ack_q) begin
                        sda_d = 1'b0;
                        ack_d = 1'b1;
                    end else begin
                        sda_d = 1'b1;
                        ack_d = 1'b0;
                        cnt_d = '0;
                        if (state_q == StWrAck || !rw_q) begin
                            state_d = StWrByte;
                        end else begin
                            scl_d   = 1'b0;
                            state_d = StRdLoad;
                        end
                    end
                end
                StWrByte: if (scl_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (push_room) begin
                            push    = 1'b1;
                            state_d = StWrAck;
                        end else begin
                            ovf_d   = 1'b1;
                            state_d = StIgnore;
                        end
                    end
                end
                StRdLoad: if (tx_ready_o && tx_valid_i) begin
                    shift_d = tx_data_i;
                    sda_d   = tx_data_i[7];
                    scl_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StRdByte;
                end
                StRdByte: if (scl_fall) begin
                    if (cnt_q == 3'd7) begin
                        sda_d   = 1'b1;
                        ack_d   = 1'b0;
                        state_d = StRdAck;
                    end else begin
                        sda_d   = shift_q[6];
                        shift_d = {shift_q[6:0], 1'b0};
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        if (sda_s) state_d = StIgnore;
                        else       ack_d   = 1'b1;
                    end else if (scl_fall && ack_q) begin
                        ack_d   = 1'b0;
                        scl_d   = 1'b0;
                        state_d = StRdLoad;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '0;
            ack_q     <= 1'b0;
            sda_q     <= 1'b1;
            scl_q     <= 1'b1;
            chan_q    <= '0;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            start_q   <= 1'b0;
            restart_q <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            ack_q     <= ack_d;
            sda_q     <= sda_d;
            scl_q     <= scl_d;
            chan_q    <= chan_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            start_q   <= start_d;
            restart_q <= restart_d;
            stop_q    <= stop_d;
        end
    end

    // A pop in the same cycle frees the slot for a push into a full FIFO.
    assign fifo_full  = (count_q == FULL_CNT);
    assign rx_valid_o = (count_q != '0);
    assign pop        = rx_ready_i & rx_valid_o;
    assign push_room  = !fifo_full || pop;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            rx_mem[wptr_q]  <= shift_in;
            tag_mem[wptr_q] <= chan_q;
        end
    end

    assign rx_data_o  = rx_valid_o ? rx_mem[rptr_q] : '0;
    assign rx_chan_o  = rx_valid_o ? tag_mem[rptr_q] : '0;
    // Bus events release both lines in the detecting cycle, ahead of the registers.
    assign sda_o      = sda_q | start_det | stop_det;
    assign scl_o      = scl_q | start_det | stop_det;
    assign tx_ready_o = (state_q == StRdLoad) && !scl_s;
    assign chan_o     = chan_q;
    assign rw_o       = rw_q;
    assign busy_o     = busy_q;
    assign start_o    = start_q;
    assign restart_o  = restart_q;
    assign stop_o     = stop_q;
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_i2c_multi_target.sv
// Bench for i2c_multi_target: bit-level I2C master, read-data provider, RX scoreboard.
module tb_i2c_multi_target;
    localparam int Q  = 8;
    localparam int CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i, m_scl, m_sda, rx_ready, tx_valid;
    logic [7:0]    tx_data, rx_data;
    logic [13:0]   addr;
    logic          scl_o, sda_o, rx_valid, tx_ready, rw, busy;
    logic          start_p, restart_p, stop_p, overflow;
    logic [CW-1:0] rx_chan, chan;
    wire           scl_bus = m_scl & scl_o;
    wire           sda_bus = m_sda & sda_o;

    int n_checks = 0, n_pass = 0;
    int n_start = 0, n_restart = 0, n_stop = 0, low_run = 0, max_low = 0;
    logic [9:0] exp_q[$];
    logic [9:0] sb_exp;
    logic       ack;
    logic [7:0] rd;
    logic [2:0] bits;

    i2c_multi_target #(
        .NUM_ADDR(2), .RX_DEPTH(2), .SYNC_STAGES(2), .GEN_CALL_EN(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .scl_i(scl_bus), .sda_i(sda_bus),
        .scl_o(scl_o), .sda_o(sda_o), .addr_i(addr),
        .rx_data_o(rx_data), .rx_chan_o(rx_chan), .rx_valid_o(rx_valid),
        .rx_ready_i(rx_ready), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready), .chan_o(chan), .rw_o(rw), .busy_o(busy),
        .start_o(start_p), .restart_o(restart_p), .stop_o(stop_p),
        .overflow_o(overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_pulse(output logic s);
        int n = 0;
        m_scl = 1'b1;
        tick(1);
        while (!scl_bus && n < 2000) begin
            tick(1);
            n++;
        end
        if (n >= 2000) check("scl_release", 32'(scl_bus), 1);
        tick(Q);
        s = sda_bus;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_rstart();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i];
            tick(Q);
            scl_pulse(s);
        end
        m_sda = 1'b1;
        tick(Q);
        scl_pulse(s);
        a = !s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        d = '0;
        m_sda = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(Q);
            scl_pulse(s);
            d = {d[6:0], s};
        end
        m_sda = nack;
        tick(Q);
        scl_pulse(s);
        m_sda = 1'b1;
    endtask

    task automatic provide(input logic [7:0] d, input int delay);
        int n = 0;
        while (!tx_ready && n < 5000) begin
            tick(1);
            n++;
        end
        check("tx_ready_seen", 32'(tx_ready), 1);
        tick(delay);
        tx_data  = d;
        tx_valid = 1'b1;
        n = 0;
        tick(1);
        while (tx_ready && n < 100) begin
            tick(1);
            n++;
        end
        tx_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        rx_ready = 1'b1;
        tick(6);
        rx_ready = 1'b0;
        tick(1);
        check({tag, "_sb_left"}, exp_q.size(), 0);
        check({tag, "_rx_empty"}, 32'(rx_valid), 0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_bits"}, {scl_o, sda_o, rx_valid, tx_ready, busy, rw, overflow,
                               start_p, restart_p, stop_p}, 10'b11_0000_0000);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_rx_chan"}, rx_chan, 0);
        check({tag, "_chan"}, chan, 0);
    endtask

    task automatic clear_counts();
        n_start = 0; n_restart = 0; n_stop = 0; max_low = 0;
    endtask

    // Event counters, SCL-hold measurement and FIFO scoreboard, sampled after the negedge.
    always begin
        @(negedge clk);
        #1;
        if (start_p)   n_start++;
        if (restart_p) n_restart++;
        if (stop_p)    n_stop++;
        if (!scl_o) begin
            low_run++;
            if (low_run > max_low) max_low = low_run;
        end else begin
            low_run = 0;
        end
        if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", exp_q.size(), 1);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_rx", {rx_chan, rx_data}, sb_exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b0; m_scl = 1'b1; m_sda = 1'b1; rx_ready = 1'b0;
        tx_valid = 1'b0; tx_data = '0; addr = {7'h2A, 7'h51};
        tick(3);
        check_reset_outs("rst");
        rst_i = 1'b1;
        tick(4);

        // Write to channel 1 (0x2A).
        clear_counts();
        i2c_start();
        write_byte(8'h54, ack);
        check("t1_addr_ack", 32'(ack), 1);
        check("t1_chan_rw_busy", {chan, rw, busy}, {2'd1, 1'b0, 1'b1});
        exp_q.push_back({2'd1, 8'hA5});
        write_byte(8'hA5, ack);
        check("t1_ack1", 32'(ack), 1);
        exp_q.push_back({2'd1, 8'h3C});
        write_byte(8'h3C, ack);
        check("t1_ack2", 32'(ack), 1);
        i2c_stop();
        check("t1_busy_off", 32'(busy), 0);
        check("t1_events", {n_start[7:0], n_stop[7:0]}, {8'd1, 8'd1});
        drain("t1");

        // Read with a 50-cycle late byte; master NACKs.
        clear_counts();
        fork
            begin
                i2c_start();
                write_byte(8'h55, ack);
                check("t2_addr_ack", 32'(ack), 1);
                check("t2_chan_rw", {chan, rw}, {2'd1, 1'b1});
                read_byte(1'b1, rd);
                check("t2_data", rd, 8'h96);
                check("t2_sda_rel", 32'(sda_o), 1);
                check("t2_tx_ready", 32'(tx_ready), 0);
                i2c_stop();
            end
            provide(8'h96, 50);
        join
        check("t2_stretch", 32'(max_low >= 50), 1);

        // Overflow with a two-entry FIFO.
        exp_q.push_back({2'd0, 8'h01});
        exp_q.push_back({2'd0, 8'h02});
        i2c_start();
        write_byte(8'hA2, ack);
        check("t3_addr_ack", 32'(ack), 1);
        write_byte(8'h01, ack);
        check("t3_ack1", 32'(ack), 1);
        write_byte(8'h02, ack);
        check("t3_ack2", 32'(ack), 1);
        check("t3_ovf_pre", 32'(overflow), 0);
        write_byte(8'h03, ack);
        check("t3_nack3", 32'(ack), 0);
        check("t3_ovf", 32'(overflow), 1);
        i2c_stop();
        drain("t3");

        // Mismatch, read to 0x00, then general call.
        i2c_start();
        write_byte(8'h26, ack);
        check("t4_miss_nack", 32'(ack), 0);
        write_byte(8'h77, ack);
        check("t4_ignored", 32'(ack), 0);
        i2c_stop();
        check("t4_fifo_empty", 32'(rx_valid), 0);
        i2c_start();
        write_byte(8'h01, ack);
        check("t4_gc_read_nack", 32'(ack), 0);
        i2c_stop();
        i2c_start();
        write_byte(8'h00, ack);
        check("t4_gc_ack", 32'(ack), 1);
        check("t4_gc_chan", chan, 2);
        exp_q.push_back({2'd2, 8'h06});
        write_byte(8'h06, ack);
        check("t4_gc_data_ack", 32'(ack), 1);
        i2c_stop();
        drain("t4");
        check("t4_ovf_sticky", 32'(overflow), 1);

        // Write then repeated START into a read.
        clear_counts();
        i2c_start();
        write_byte(8'h54, ack);
        check("t5_addr_ack", 32'(ack), 1);
        exp_q.push_back({2'd1, 8'h11});
        write_byte(8'h11, ack);
        check("t5_data_ack", 32'(ack), 1);
        check("t5_rw_wr", 32'(rw), 0);
        i2c_rstart();
        check("t5_restart", n_restart, 1);
        write_byte(8'h55, ack);
        check("t5_raddr_ack", 32'(ack), 1);
        check("t5_rw_rd", 32'(rw), 1);
        fork
            read_byte(1'b1, rd);
            provide(8'hC3, 0);
        join
        check("t5_data", rd, 8'hC3);
        i2c_stop();
        drain("t5");

        // Reset while the target drives the fourth read bit.
        i2c_start();
        write_byte(8'h55, ack);
        check("t6_addr_ack", 32'(ack), 1);
        fork
            begin
                logic s;
                m_sda = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    tick(Q);
                    scl_pulse(s);
                    bits = {bits[1:0], s};
                end
            end
            provide(8'hE5, 0);
        join
        tick(2);
        check("t6_bits", bits, 3'b111);
        check("t6_sda_pre", 32'(sda_o), 0);
        rst_i = 1'b0;
        tick(1);
        check_reset_outs("t6");
        rst_i = 1'b1;
        m_scl = 1'b1;
        m_sda = 1'b1;
        tick(Q);
        check("t6_idle_busy", 32'(busy), 0);
        check("sb_final", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
